// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings, flag bit
// positions and the shifter mode type.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned FLAG_W    = 3;

  localparam logic [OP_W-1:0] ALU_ADD   = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUB   = 5'b00001;
  localparam logic [OP_W-1:0] ALU_AND   = 5'b00010;
  localparam logic [OP_W-1:0] ALU_OR    = 5'b00011;
  localparam logic [OP_W-1:0] ALU_XOR   = 5'b00100;
  localparam logic [OP_W-1:0] ALU_NOR   = 5'b00101;
  localparam logic [OP_W-1:0] ALU_NOT   = 5'b00110;
  localparam logic [OP_W-1:0] ALU_SLL   = 5'b00111;
  localparam logic [OP_W-1:0] ALU_SRL   = 5'b01000;
  localparam logic [OP_W-1:0] ALU_SRA   = 5'b01001;
  localparam logic [OP_W-1:0] ALU_SLT   = 5'b01010;
  localparam logic [OP_W-1:0] ALU_SLTU  = 5'b01011;
  localparam logic [OP_W-1:0] ALU_PASSB = 5'b01100;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter with shift-out carry.
//   a      : value to shift
//   shamt  : shift amount (0..WIDTH-1)
//   mode   : SH_SLL / SH_SRL / SH_SRA
//   result : shifted value
//   carry  : last bit shifted out, 0 when shamt is 0
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // One guard bit on the exit side catches the last bit shifted out.
  logic [WIDTH:0]        sll_c;
  logic [WIDTH:0]        srl_c;
  logic signed [WIDTH:0] sra_c;

  assign sll_c = {1'b0, a} << shamt;
  assign srl_c = {a, 1'b0} >> shamt;
  assign sra_c = $signed({a, 1'b0}) >>> shamt;

  // Select the shift flavour.
  always_comb begin
    result = a;
    carry  = 1'b0;
    case (mode)
      SH_SLL: begin
        result = sll_c[WIDTH-1:0];
        carry  = sll_c[WIDTH];
      end
      SH_SRL: begin
        result = srl_c[WIDTH:1];
        carry  = srl_c[0];
      end
      SH_SRA: begin
        result = sra_c[WIDTH:1];
        carry  = sra_c[0];
      end
      default: begin
        result = a;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Registered integer ALU for the execute stage.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   A, B     : operands (B[SHW-1:0] is the shift amount)
//   controls : opcode
//   flags    : registered {overflow, zero, carry}
//   out      : registered result
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [OP_W-1:0]   controls,
  output logic [FLAG_W-1:0] flags,
  output logic [WIDTH-1:0]  out
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]      sum_c;
  logic [WIDTH:0]      diff_c;
  logic [WIDTH-1:0]    sh_res_c;
  logic                sh_carry_c;
  shift_mode_e         sh_mode_c;
  logic [WIDTH-1:0]    res_c;
  logic                carry_c;
  logic                ovf_c;
  logic [FLAG_W-1:0]   flags_c;

  // Subtraction as A + ~B + 1 so the carry-out means "no borrow".
  assign sum_c  = {1'b0, A} + {1'b0, B};
  assign diff_c = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

  // Shifter mode decode.
  always_comb begin
    sh_mode_c = SH_SLL;
    case (controls)
      ALU_SRL: sh_mode_c = SH_SRL;
      ALU_SRA: sh_mode_c = SH_SRA;
      default: sh_mode_c = SH_SLL;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .a      (A),
    .shamt  (B[SHW-1:0]),
    .mode   (sh_mode_c),
    .result (sh_res_c),
    .carry  (sh_carry_c)
  );

  // Result, carry and overflow selection; undefined opcodes yield zero.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (controls)
      ALU_ADD: begin
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (A[MSB] == B[MSB]) && (sum_c[MSB] != A[MSB]);
      end
      ALU_SUB: begin
        res_c   = diff_c[WIDTH-1:0];
        carry_c = diff_c[WIDTH];
        ovf_c   = (A[MSB] != B[MSB]) && (diff_c[MSB] != A[MSB]);
      end
      ALU_AND:   res_c = A & B;
      ALU_OR:    res_c = A | B;
      ALU_XOR:   res_c = A ^ B;
      ALU_NOR:   res_c = ~(A | B);
      ALU_NOT:   res_c = ~A;
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        res_c   = sh_res_c;
        carry_c = sh_carry_c;
      end
      ALU_SLT:   res_c = WIDTH'($signed(A) < $signed(B));
      ALU_SLTU:  res_c = WIDTH'(A < B);
      ALU_PASSB: res_c = B;
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
      end
    endcase
  end

  // Flag vector assembly.
  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_C] = carry_c;
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_V] = ovf_c;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      flags <= '0;
    end else begin
      out   <= res_c;
      flags <= flags_c;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors from the test plan
// plus a randomized back-to-back stream checked against a bit-level model.
module tb_alu_core;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  controls;
  logic [2:0]  flags;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  // Expected {flags, out} in issue order.
  logic [34:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] o;
    logic [2:0]  f;
  } vec_t;

  alu_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .controls (controls),
    .flags    (flags),
    .out      (out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Independent reference: shifts done one bit at a time, sub via compare.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    logic [31:0] r;
    logic [32:0] s;
    logic        c;
    logic        v;
    int          n;
    r = 32'd0; c = 1'b0; v = 1'b0; s = 33'd0;
    n = int'(b[4:0]);
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd1: begin
        r = a - b; c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = ~(a | b);
      5'd6:  r = ~a;
      5'd7:  begin r = a; for (int i = 0; i < n; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end end
      5'd8:  begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {1'b0, r[31:1]}; end end
      5'd9:  begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {r[31], r[31:1]}; end end
      5'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd11: r = (a < b) ? 32'd1 : 32'd0;
      5'd12: r = b;
      default: r = 32'd0;
    endcase
    return {v, (r == 32'd0), c, r};
  endfunction

  // Drive one operation and record its expected outcome.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [34:0] exp);
    A = a; B = b; controls = op;
    sb.push_back(exp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; A = 32'd5; B = 32'd5; controls = ALU_ADD;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out !== 32'd0 || flags !== 3'b000) begin
        errors++;
        $display("FAIL reset[%0d]: out=%h flags=%b, expected out=00000000 flags=000", i, out, flags);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out !== 32'd10 || flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: out=%h flags=%b, expected out=0000000a flags=000", out, flags);
    end
  endtask

  task automatic test_add();
    vec_t v[6];
    logic [34:0] exp;
    v = '{'{32'd1,         32'd2,    ALU_ADD, 32'd3,         3'b000},
          '{32'd512,       32'd1024, ALU_ADD, 32'd1536,      3'b000},
          '{32'd150,       32'd4,    ALU_ADD, 32'd154,       3'b000},
          '{32'd1243,      32'd10,   ALU_ADD, 32'd1253,      3'b000},
          '{32'hFFFFFFFF,  32'd1,    ALU_ADD, 32'h00000000,  3'b011},
          '{32'h7FFFFFFF,  32'd1,    ALU_ADD, 32'h80000000,  3'b100}};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op, {v[i].f, v[i].o});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (out !== exp[31:0] || flags !== exp[34:32]) begin
        errors++;
        $display("FAIL add[%0d]: out=%h flags=%b, expected out=%h flags=%b",
                 i, out, flags, exp[31:0], exp[34:32]);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[3];
    logic [34:0] exp;
    v = '{'{32'd5,         32'd5, ALU_SUB, 32'h00000000, 3'b011},
          '{32'd3,         32'd5, ALU_SUB, 32'hFFFFFFFE, 3'b000},
          '{32'h80000000,  32'd1, ALU_SUB, 32'h7FFFFFFF, 3'b101}};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op, {v[i].f, v[i].o});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (out !== exp[31:0] || flags !== exp[34:32]) begin
        errors++;
        $display("FAIL sub[%0d]: out=%h flags=%b, expected out=%h flags=%b",
                 i, out, flags, exp[31:0], exp[34:32]);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[6];
    logic [34:0] exp;
    // B upper bits set to confirm only B[4:0] is used as the amount.
    v = '{'{32'h80000001, 32'd1,         ALU_SLL, 32'h00000002, 3'b001},
          '{32'h80000001, 32'd1,         ALU_SRL, 32'h40000000, 3'b001},
          '{32'h80000001, 32'd4,         ALU_SRA, 32'hF8000000, 3'b000},
          '{32'h80000001, 32'd0,         ALU_SLL, 32'h80000001, 3'b000},
          '{32'h80000001, 32'hFFFFFFE0,  ALU_SRA, 32'h80000001, 3'b000},
          '{32'h80000001, 32'd31,        ALU_SRL, 32'h00000001, 3'b000}};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op, {v[i].f, v[i].o});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (out !== exp[31:0] || flags !== exp[34:32]) begin
        errors++;
        $display("FAIL shift[%0d]: out=%h flags=%b, expected out=%h flags=%b",
                 i, out, flags, exp[31:0], exp[34:32]);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[6];
    logic [34:0] exp;
    v = '{'{32'hF0F0F0F0, 32'hFF00FF00, ALU_AND,  32'hF000F000, 3'b000},
          '{32'hF0F0F0F0, 32'hFF00FF00, ALU_OR,   32'hFFF0FFF0, 3'b000},
          '{32'hF0F0F0F0, 32'hFF00FF00, ALU_XOR,  32'h0FF00FF0, 3'b000},
          '{32'hFFFFFFFF, 32'd1,        ALU_SLT,  32'h00000001, 3'b000},
          '{32'hFFFFFFFF, 32'd1,        ALU_SLTU, 32'h00000000, 3'b010},
          '{32'h12345678, 32'h9ABCDEF0, 5'b11111, 32'h00000000, 3'b010}};
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].op, {v[i].f, v[i].o});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (out !== exp[31:0] || flags !== exp[34:32]) begin
        errors++;
        $display("FAIL logic[%0d]: out=%h flags=%b, expected out=%h flags=%b",
                 i, out, flags, exp[31:0], exp[34:32]);
      end
    end
  endtask

  // One new operation every cycle; each result is checked the cycle after.
  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [34:0] exp;
    for (int i = 0; i <= 60; i++) begin
      if (i > 0) begin
        @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if (out !== exp[31:0] || flags !== exp[34:32]) begin
          errors++;
          $display("FAIL b2b[%0d]: out=%h flags=%b, expected out=%h flags=%b",
                   i - 1, out, flags, exp[31:0], exp[34:32]);
        end
      end
      if (i < 60) begin
        a  = $urandom();
        b  = $urandom();
        op = 5'($urandom_range(0, 15));
        if (i % 7 == 0) b = a;
        if (i % 11 == 0) a = 32'h7FFFFFFF;
        issue(a, b, op, model(a, b, op));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; controls = '0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
